// File: rtl/id_ex_stage.sv
// -----------------------------------------------------------------------------
// id_ex_stage
//
// ID/EX pipeline register with load-use hazard detection, bubble insertion,
// a saturating bubble counter and an optional WB-to-ID write-through bypass.
//
// Build option:
//   ID_EX_WB_BYPASS_EN  when defined, a register being written back in the same
//                       cycle is forwarded into EX_ReadData1/EX_ReadData2 on
//                       load. When undefined, the WB_* ports are ignored and the
//                       register file must provide write-before-read itself.
//
// Ports:
//   Clk, Rst_n                  clock (rising edge), async active-low reset
//   ReadData1/ReadData2         register file data for Rs/Rt
//   Rs, Rt, Rd                  register specifiers from ID
//   Imm, PCPlus4                immediate and PC+4 of the ID instruction
//   CtrlIn                      decoded control bundle
//                               (bit0 RegWrite, bit1 MemRead, bit2 MemWrite,
//                                bit3 MemToReg, bit4 ALUSrc, bit5 RegDst,
//                                bit6 Branch, bits[11:7] ALUOp)
//   ValidIn                     ID holds a real instruction
//   Flush                       kill the ID instruction (branch taken in EX)
//   WB_RegWrite/WriteRegister/WriteData  write-back port for the bypass
//   Stall                       combinational hold request for PC and IF/ID
//   EX_*                        registered operands, specifiers and control
//   EX_Valid                    EX holds a real instruction
//   BubbleCount                 saturating count of inserted bubbles
// -----------------------------------------------------------------------------
module id_ex_stage #(
   parameter int DATA_W = 32,
   parameter int CTRL_W = 12,
   parameter int CNT_W  = 16
) (
   input  logic              Clk,
   input  logic              Rst_n,
   input  logic [DATA_W-1:0] ReadData1,
   input  logic [DATA_W-1:0] ReadData2,
   input  logic [4:0]        Rs,
   input  logic [4:0]        Rt,
   input  logic [4:0]        Rd,
   input  logic [DATA_W-1:0] Imm,
   input  logic [DATA_W-1:0] PCPlus4,
   input  logic [CTRL_W-1:0] CtrlIn,
   input  logic              ValidIn,
   input  logic              Flush,
   input  logic              WB_RegWrite,
   input  logic [4:0]        WB_WriteRegister,
   input  logic [DATA_W-1:0] WB_WriteData,
   output logic              Stall,
   output logic [DATA_W-1:0] EX_ReadData1,
   output logic [DATA_W-1:0] EX_ReadData2,
   output logic [DATA_W-1:0] EX_Imm,
   output logic [DATA_W-1:0] EX_PCPlus4,
   output logic [4:0]        EX_Rs,
   output logic [4:0]        EX_Rt,
   output logic [4:0]        EX_Rd,
   output logic [CTRL_W-1:0] EX_Ctrl,
   output logic              EX_Valid,
   output logic [CNT_W-1:0]  BubbleCount
);

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   logic              hazard;
   logic              bubble;
   logic [DATA_W-1:0] operandA;
   logic [DATA_W-1:0] operandB;

   // Load in EX whose destination (Rt) is a source of the ID instruction.
   // EX_Rt != 0 also guarantees the matching ID specifier is non-zero.
   always_comb begin
      hazard = EX_Valid & EX_Ctrl[1] & ValidIn & (EX_Rt != 5'd0) &
               ((EX_Rt == Rs) | (EX_Rt == Rt));
   end

   // Flush outranks the hazard: the stalled instruction is being killed anyway.
   // Gating with Rst_n keeps Stall low while the pipeline is held in reset.
   assign Stall  = hazard & ~Flush & Rst_n;
   assign bubble = Flush | hazard;

   always_comb begin
      operandA = ReadData1;
      operandB = ReadData2;
`ifdef ID_EX_WB_BYPASS_EN
      if (WB_RegWrite && (WB_WriteRegister != 5'd0) && (WB_WriteRegister == Rs))
         operandA = WB_WriteData;
      if (WB_RegWrite && (WB_WriteRegister != 5'd0) && (WB_WriteRegister == Rt))
         operandB = WB_WriteData;
`endif
      // Register 0 reads as zero whatever the register file presents.
      if (Rs == 5'd0)
         operandA = '0;
      if (Rt == 5'd0)
         operandB = '0;
   end

`ifndef ID_EX_WB_BYPASS_EN
   // WB port exists for interface compatibility only in this build.
   logic unusedWb;
   assign unusedWb = &{1'b0, WB_RegWrite, WB_WriteRegister, WB_WriteData};
`endif

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         EX_ReadData1 <= '0;
         EX_ReadData2 <= '0;
         EX_Imm       <= '0;
         EX_PCPlus4   <= '0;
         EX_Rs        <= '0;
         EX_Rt        <= '0;
         EX_Rd        <= '0;
         EX_Ctrl      <= '0;
         EX_Valid     <= 1'b0;
         BubbleCount  <= '0;
      end else if (bubble) begin
         EX_ReadData1 <= '0;
         EX_ReadData2 <= '0;
         EX_Imm       <= '0;
         EX_PCPlus4   <= '0;
         EX_Rs        <= '0;
         EX_Rt        <= '0;
         EX_Rd        <= '0;
         EX_Ctrl      <= '0;
         EX_Valid     <= 1'b0;
         if (BubbleCount != {CNT_W{1'b1}})
            BubbleCount <= BubbleCount + CNT_ONE;
      end else begin
         EX_ReadData1 <= operandA;
         EX_ReadData2 <= operandB;
         EX_Imm       <= Imm;
         EX_PCPlus4   <= PCPlus4;
         EX_Rs        <= Rs;
         EX_Rt        <= Rt;
         EX_Rd        <= Rd;
         // An empty ID slot travels as a non-counted NOP.
         EX_Ctrl      <= ValidIn ? CtrlIn : '0;
         EX_Valid     <= ValidIn;
      end
   end

endmodule
